// File: rtl/alu_pkg.sv
// Shared types for the ALU issue front end: opcode map and response FIFO entry.
package alu_pkg;

  localparam int unsigned ALU_W = 8;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_OR  = 3'd3,
    OP_LSH = 3'd4,
    OP_RSH = 3'd5,
    OP_CMP = 3'd6,
    OP_ILL = 3'd7
  } aluop_t;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             zero;
    logic             par;
    logic             co;
    logic             err;
  } resp_t;

endpackage

// File: rtl/alu_resp_fifo.sv
// Circular response FIFO; pointers wrap mod DEPTH, occupancy kept in a separate count.
module alu_resp_fifo import alu_pkg::*; #(
  parameter int unsigned DEPTH = 3,
  parameter type         T     = resp_t,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  T              mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Requester front end for the combinational ALU: issue register, result capture,
// in-order response FIFO and architectural Z/P/C flags.
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned DEPTH = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] DatA,
  output logic [W-1:0] DatB,
  output logic [2:0]   Aluop,
  input  logic [W-1:0] Rslt,
  input  logic         Zero,
  input  logic         Par,
  input  logic         SCo,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_zero,
  output logic         resp_par,
  output logic         resp_co,
  output logic         resp_err,
  output logic         FlagZ,
  output logic         FlagP,
  output logic         FlagC
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic          s1_valid;
  aluop_t        s1_op;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occupancy;
  resp_t         push_entry;
  resp_t         head;

  // Reserve a FIFO slot for whatever is in S1 so its capture can never overflow.
  assign occupancy = {1'b0, fifo_count} + OW'(s1_valid);
  assign cmd_ready = !Reset && (occupancy < OW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = s1_valid && !fifo_full;
  assign pop       = resp_ready && !fifo_empty;

  assign DatA  = s1_a;
  assign DatB  = s1_b;
  assign Aluop = 3'(s1_op);

  always_comb begin
    push_entry = '0;
    if (s1_op == OP_ILL) begin
      push_entry.err = 1'b1;
    end else begin
      push_entry.data = ALU_W'(Rslt);
      push_entry.zero = Zero;
      push_entry.par  = Par;
      push_entry.co   = SCo;
    end
  end

  // S1 operands hold when idle so the ALU inputs do not toggle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
      FlagZ    <= 1'b0;
      FlagP    <= 1'b0;
      FlagC    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= aluop_t'(cmd_op);
        s1_a  <= cmd_a;
        s1_b  <= cmd_b;
      end
      if (push && !push_entry.err) begin
        FlagZ <= push_entry.zero;
        FlagP <= push_entry.par;
        FlagC <= push_entry.co;
      end
    end
  end

  alu_resp_fifo #(
    .DEPTH (DEPTH),
    .T     (resp_t)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Response fields read zero whenever the FIFO is empty.
  always_comb begin
    resp_valid = !fifo_empty;
    resp_data  = '0;
    resp_zero  = 1'b0;
    resp_par   = 1'b0;
    resp_co    = 1'b0;
    resp_err   = 1'b0;
    if (!fifo_empty) begin
      resp_data = W'(head.data);
      resp_zero = head.zero;
      resp_par  = head.par;
      resp_co   = head.co;
      resp_err  = head.err;
    end
  end

endmodule
